cafu_err_cnt_csr: RTL and testbench

CAFU_ERR_CNT_CSR -- requirements
Module: cafu_err_cnt_csr

---
 rtl/ext_csr_if_pkg.sv | 54 +++++
 rtl/sat_cnt32.sv | 31 +++
 rtl/cafu_err_cnt_csr.sv | 126 ++++++++++++
 tb/tb_cafu_err_cnt_csr.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_csr_if_pkg.sv
// Shared types and constants for the error-counter CSR block.
//   csr_req_t    : CSR request {data, addr, valid}, 97 bits
//   csr_rsp_t    : CSR response {data, valid}, 65 bits
//   mc_err_cnt_t : live counters {uncorr, corr}, 64 bits
//   csr_state_e  : request/response handshake states
//   sat_next()   : next value of a 32-bit saturating counter with clear
package ext_csr_if_pkg;

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] addr;
        logic        valid;
    } csr_req_t;

    typedef struct packed {
        logic [63:0] data;
        logic        valid;
    } csr_rsp_t;

    typedef struct packed {
        logic [31:0] uncorr;
        logic [31:0] corr;
    } mc_err_cnt_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RSP  = 1'b1
    } csr_state_e;

    localparam logic [7:0] CSR_OFF_CNT    = 8'h00;
    localparam logic [7:0] CSR_OFF_SHADOW = 8'h08;
    localparam logic [7:0] CSR_OFF_CLR    = 8'h10;
    localparam logic [7:0] CSR_OFF_THR    = 8'h18;

    localparam int unsigned W1C_CORR_BIT   = 0;
    localparam int unsigned W1C_UNCORR_BIT = 1;
    localparam int unsigned W1C_IRQ_BIT    = 2;

    localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

    // Clear wins over the old value, but an increment in the same cycle
    // still counts, so clear+inc lands on 1.
    function automatic logic [31:0] sat_next(input logic [31:0] cnt,
                                             input logic        inc,
                                             input logic        clr);
        logic [31:0] base;
        base = clr ? 32'd0 : cnt;
        if (inc && (base != SAT_MAX)) begin
            return base + 32'd1;
        end
        return base;
    endfunction

endpackage

// File: rtl/sat_cnt32.sv
// 32-bit saturating event counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one event this cycle
//   clr        : clear this cycle (clear+inc gives 1)
//   count      : current count, straight from the register
module sat_cnt32
    import ext_csr_if_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    assign count_d = sat_next(count_q, inc, clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cafu_err_cnt_csr.sv
// Memory error counters with a small CSR front end.
//   clk, rst_n      : clock, async active-low reset
//   csr_req_i       : request {data, addr, valid}; csr_req_wr_i = 1 for write
//   csr_req_ready_o : high when a request can be taken this cycle
//   csr_rsp_o       : response, valid for one cycle after accept
//   err_corr_i      : one correctable error per high cycle
//   err_uncorr_i    : one uncorrectable error per high cycle
//   err_cnt_o       : live {uncorr, corr} counters
//   err_irq_o       : sticky correctable-threshold interrupt
//
// state   | meaning
// IDLE    | ready, waiting for a request
// RSP     | presenting the response, new requests ignored
module cafu_err_cnt_csr
    import ext_csr_if_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  csr_req_t    csr_req_i,
    input  logic        csr_req_wr_i,
    output logic        csr_req_ready_o,
    output csr_rsp_t    csr_rsp_o,
    input  logic        err_corr_i,
    input  logic        err_uncorr_i,
    output mc_err_cnt_t err_cnt_o,
    output logic        err_irq_o
);

    csr_state_e  state_q, state_d;
    csr_rsp_t    rsp_q, rsp_d;
    logic [63:0] shadow_q, shadow_d;
    logic [31:0] thr_q, thr_d;
    logic        irq_q, irq_d;

    logic        clr_corr, clr_uncorr, clr_irq;
    logic [31:0] corr_cnt, uncorr_cnt, corr_nxt;
    logic        mapped;
    logic [7:0]  off;
    logic        unused_data;

    assign mapped      = (csr_req_i.addr[31:8] == 24'd0);
    assign off         = csr_req_i.addr[7:0];
    assign unused_data = ^csr_req_i.data[63:32];

    sat_cnt32 u_cnt_corr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_corr_i),
        .clr   (clr_corr),
        .count (corr_cnt)
    );

    sat_cnt32 u_cnt_uncorr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_uncorr_i),
        .clr   (clr_uncorr),
        .count (uncorr_cnt)
    );

    always_comb begin
        state_d         = state_q;
        rsp_d           = '0;
        shadow_d        = shadow_q;
        thr_d           = thr_q;
        clr_corr        = 1'b0;
        clr_uncorr      = 1'b0;
        clr_irq         = 1'b0;
        csr_req_ready_o = (state_q == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (csr_req_i.valid) begin
                    state_d     = ST_RSP;
                    rsp_d.valid = 1'b1;
                    if (mapped && csr_req_wr_i) begin
                        if (off == CSR_OFF_CLR) begin
                            clr_corr   = csr_req_i.data[W1C_CORR_BIT];
                            clr_uncorr = csr_req_i.data[W1C_UNCORR_BIT];
                            clr_irq    = csr_req_i.data[W1C_IRQ_BIT];
                        end else if (off == CSR_OFF_THR) begin
                            thr_d = csr_req_i.data[31:0];
                        end
                    end else if (mapped) begin
                        if (off == CSR_OFF_CNT) begin
                            rsp_d.data = {uncorr_cnt, corr_cnt};
                            shadow_d   = {uncorr_cnt, corr_cnt};
                        end else if (off == CSR_OFF_SHADOW) begin
                            rsp_d.data = shadow_q;
                        end else if (off == CSR_OFF_THR) begin
                            rsp_d.data = {32'd0, thr_q};
                        end
                    end
                end
            end
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Compare against the value the counter will hold after this edge so
    // the interrupt lines up with the count that crosses the threshold.
    assign corr_nxt = sat_next(corr_cnt, err_corr_i, clr_corr);
    assign irq_d    = ((thr_q != 32'd0) && (corr_nxt >= thr_q)) || (irq_q && !clr_irq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rsp_q    <= '0;
            shadow_q <= '0;
            thr_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rsp_q    <= rsp_d;
            shadow_q <= shadow_d;
            thr_q    <= thr_d;
            irq_q    <= irq_d;
        end
    end

    assign csr_rsp_o        = rsp_q;
    assign err_irq_o        = irq_q;
    assign err_cnt_o.uncorr = uncorr_cnt;
    assign err_cnt_o.corr   = corr_cnt;

endmodule

// File: tb/tb_cafu_err_cnt_csr.sv
module tb_cafu_err_cnt_csr;
    import ext_csr_if_pkg::*;

    logic        clk;
    logic        rst_n;
    csr_req_t    req;
    logic        req_wr;
    logic        ready;
    csr_rsp_t    rsp;
    logic        err_corr;
    logic        err_uncorr;
    mc_err_cnt_t cnt;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    cafu_err_cnt_csr dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .csr_req_i       (req),
        .csr_req_wr_i    (req_wr),
        .csr_req_ready_o (ready),
        .csr_rsp_o       (rsp),
        .err_corr_i      (err_corr),
        .err_uncorr_i    (err_uncorr),
        .err_cnt_o       (cnt),
        .err_irq_o       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural reference state
    longint unsigned m_corr, m_uncorr;
    logic [63:0]     m_shadow, m_rsp_data;
    logic [31:0]     m_thr;
    bit              m_irq, m_busy, m_rsp_valid;

    localparam longint unsigned CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    task automatic model_reset();
        m_corr = 0; m_uncorr = 0; m_shadow = '0; m_rsp_data = '0;
        m_thr = '0; m_irq = 0; m_busy = 0; m_rsp_valid = 0;
    endtask

    task automatic model_step(input logic v, input logic wr, input logic [31:0] addr,
                              input logic [63:0] data, input logic ec, input logic eu);
        bit acc, mapped, clrc, clru, clri;
        longint unsigned nc, nu;
        logic [63:0] cur;
        acc = v && !m_busy;
        mapped = (addr < 32'h100);
        clrc = 0; clru = 0; clri = 0;
        m_rsp_data = '0;
        cur = {m_uncorr[31:0], m_corr[31:0]};
        if (acc && mapped) begin
            if (wr) begin
                if (addr == 32'h10) begin
                    clrc = data[0]; clru = data[1]; clri = data[2];
                end else if (addr == 32'h18) begin
                    m_thr = data[31:0];
                end
            end else begin
                if (addr == 32'h00) begin
                    m_rsp_data = cur; m_shadow = cur;
                end else if (addr == 32'h08) begin
                    m_rsp_data = m_shadow;
                end else if (addr == 32'h18) begin
                    m_rsp_data = {32'd0, m_thr};
                end
            end
        end
        nc = clrc ? 0 : m_corr;
        if (ec && nc < CNT_MAX) nc = nc + 1;
        nu = clru ? 0 : m_uncorr;
        if (eu && nu < CNT_MAX) nu = nu + 1;
        // threshold used here is the one held before this cycle's write
        m_irq = (m_irq && !clri) || (m_thr_prev != 0 && nc >= m_thr_prev);
        m_corr = nc; m_uncorr = nu;
        m_rsp_valid = acc;
        m_busy = acc;
    endtask

    logic [31:0] m_thr_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_ready"}, {63'd0, ready}, {63'd0, !m_busy});
        chk({tag, "_rsp_valid"}, {63'd0, rsp.valid}, {63'd0, m_rsp_valid});
        chk({tag, "_rsp_data"}, rsp.data, m_rsp_data);
        chk({tag, "_cnt"}, cnt, {m_uncorr[31:0], m_corr[31:0]});
        chk({tag, "_irq"}, {63'd0, irq}, {63'd0, m_irq});
    endtask

    // Called at posedge+1; applies inputs for one cycle and checks after the edge.
    task automatic do_cycle(input logic v, input logic wr, input logic [31:0] addr,
                            input logic [63:0] data, input logic ec, input logic eu,
                            input string tag);
        req.valid = v; req.addr = addr; req.data = data; req_wr = wr;
        err_corr = ec; err_uncorr = eu;
        m_thr_prev = m_thr;
        model_step(v, wr, addr, data, ec, eu);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    typedef struct {
        logic        v, wr;
        logic [31:0] addr;
        logic [63:0] data;
        logic        ec, eu;
        logic        e_valid;
        logic [63:0] e_data;
        logic        e_ready;
        logic [31:0] e_corr, e_uncorr;
        logic        e_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic wr, logic [31:0] a, logic [63:0] d, logic ec,
                                logic eu, logic ev, logic [63:0] ed, logic er,
                                logic [31:0] ecr, logic [31:0] eun, logic ei);
        vec_t t;
        t.v = v; t.wr = wr; t.addr = a; t.data = d; t.ec = ec; t.eu = eu;
        t.e_valid = ev; t.e_data = ed; t.e_ready = er; t.e_corr = ecr; t.e_uncorr = eun;
        t.e_irq = ei;
        return t;
    endfunction

    initial begin
        logic        v, wr, ec, eu;
        logic [31:0] addr;
        logic [63:0] data;

        rst_n = 1'b0; req = '0; req_wr = 1'b0; err_corr = 1'b0; err_uncorr = 1'b0;
        model_reset();
        m_thr_prev = '0;

        //         v  wr addr    data ec eu | val data ry corr uncorr irq
        tbl.push_back(mk(0, 0, 32'h00,  0, 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00,  0, 1, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00,  0, 1, 0, 0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00,  0, 1, 0, 0, 0, 1, 4, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00,  0, 1, 0, 0, 0, 1, 5, 0, 0));
        tbl.push_back(mk(1, 0, 32'h00,  0, 0, 0, 1, 5, 0, 5, 0, 0));
        tbl.push_back(mk(1, 0, 32'h08,  0, 0, 0, 0, 0, 1, 5, 0, 0));
        tbl.push_back(mk(1, 0, 32'h08,  0, 0, 0, 1, 5, 0, 5, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00,  0, 0, 1, 0, 0, 1, 5, 1, 0));
        tbl.push_back(mk(1, 0, 32'h100, 0, 0, 0, 1, 0, 0, 5, 1, 0));
        tbl.push_back(mk(0, 0, 32'h00,  0, 0, 0, 0, 0, 1, 5, 1, 0));
        tbl.push_back(mk(1, 1, 32'h10,  3, 1, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00,  0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 32'h10,  1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00,  0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h18,  4, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00,  0, 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h18,  0, 1, 0, 1, 4, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00,  0, 1, 0, 0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00,  0, 1, 0, 0, 0, 1, 4, 0, 1));
        tbl.push_back(mk(0, 0, 32'h00,  0, 0, 0, 0, 0, 1, 4, 0, 1));
        tbl.push_back(mk(1, 1, 32'h10,  4, 0, 0, 1, 0, 0, 4, 0, 1));
        tbl.push_back(mk(0, 0, 32'h00,  0, 0, 0, 0, 0, 1, 4, 0, 1));
        tbl.push_back(mk(1, 1, 32'h18,  0, 0, 0, 1, 0, 0, 4, 0, 1));
        tbl.push_back(mk(0, 0, 32'h00,  0, 0, 0, 0, 0, 1, 4, 0, 1));
        tbl.push_back(mk(1, 1, 32'h10,  4, 0, 0, 1, 0, 0, 4, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00,  0, 0, 0, 0, 0, 1, 4, 0, 0));

        // reset and first cycle after release
        repeat (2) @(posedge clk);
        #1;
        chk("in_reset_rsp", rsp, '0);
        chk("in_reset_cnt", cnt, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_all("post_reset");

        // directed table
        foreach (tbl[i]) begin
            do_cycle(tbl[i].v, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].ec, tbl[i].eu, "tbl");
            chk($sformatf("tbl%0d_valid", i), {63'd0, rsp.valid}, {63'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_data", i), rsp.data, tbl[i].e_data);
            chk($sformatf("tbl%0d_ready", i), {63'd0, ready}, {63'd0, tbl[i].e_ready});
            chk($sformatf("tbl%0d_cnt", i), cnt, {tbl[i].e_uncorr, tbl[i].e_corr});
            chk($sformatf("tbl%0d_irq", i), {63'd0, irq}, {63'd0, tbl[i].e_irq});
        end

        // saturation: preload the correctable counter just below the ceiling
        force dut.u_cnt_corr.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_cnt_corr.count_q;
        m_corr = 64'h0000_0000_FFFF_FFFE;
        do_cycle(0, 0, 0, 0, 0, 0, "preload");
        for (int k = 0; k < 3; k++) do_cycle(0, 0, 0, 0, 1, 0, "sat");
        chk("sat_corr", {32'd0, cnt.corr}, 64'h0000_0000_FFFF_FFFF);
        do_cycle(1, 0, 32'h00, 0, 1, 0, "sat_rd");
        chk("sat_rd_data", rsp.data[31:0], 64'h0000_0000_FFFF_FFFF);

        // randomized traffic against the reference model
        for (int k = 0; k < 800; k++) begin
            v  = ($urandom_range(0, 2) == 0);
            wr = $urandom_range(0, 1);
            case ($urandom_range(0, 7))
                0: addr = 32'h00;
                1: addr = 32'h08;
                2: addr = ($urandom_range(0, 3) == 0) ? 32'h10 : 32'h08;
                3: addr = 32'h18;
                4: addr = 32'h04;
                5: addr = 32'h100;
                6: addr = $urandom;
                default: addr = 32'h18;
            endcase
            data = {$urandom, $urandom};
            if (addr == 32'h18) data[31:0] = ($urandom_range(0, 5) == 0) ? 32'd0 :
                                              32'($urandom_range(1, 40));
            ec = $urandom_range(0, 1);
            eu = ($urandom_range(0, 3) == 0);
            do_cycle(v, wr, addr, data, ec, eu, "rnd");
        end

        // reset while a response is pending
        do_cycle(0, 0, 0, 0, 0, 0, "pre_rst");
        do_cycle(1, 0, 32'h00, 0, 1, 1, "rst_acc");
        req = '0; req_wr = 1'b0; err_corr = 1'b0; err_uncorr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", {63'd0, rsp.valid}, 64'd0);
        chk("rst_rsp", rsp, '0);
        chk("rst_cnt", cnt, '0);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_rsp", rsp, '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        m_thr_prev = '0;
        @(posedge clk);
        #1;
        compare_all("rst_release");
        do_cycle(1, 0, 32'h18, 0, 0, 0, "rst_thr_rd");
        chk("rst_thr_zero", rsp.data, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
